fifo_mem_param: RTL and testbench
=================================

Name: fifo_mem_param

Overview:
Parametrised synchronous FIFO buffer. It is the next generation of the team's single-port pointer memory, adding:
- configurable depth
- full/empty and almost-full/almost-empty flags
- fill-level output
- overflow/underflow protection
- a registered valid strobe on read data

It sits between data-producing and data-consuming stages of the datapath, in a single clock domain.

Parameters:
DATA_WIDTH, 10, bits per word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH words (default 8)
ALMOST_FULL_TH, 6, almost_full asserted when level >= this value
ALMOST_EMPTY_TH, 2, almost_empty asserted when level <= this value

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a word popped on the previous edge
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= ALMOST_FULL_TH
almost_empty  output  1  level <= ALMOST_EMPTY_TH
fill_level  output  ADDR_WIDTH+1  words currently stored (0..DEPTH)
overflow  output  1  sticky: a write was attempted while full and dropped
underflow  output  1  sticky: a read was attempted while empty and ignored

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high. On assertion, immediately clear:
  - wr_ptr, rd_ptr, fill_level
  - data_out = 0, valid_out = 0
  - overflow = 0, underflow = 0
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Storage array contents are not cleared by reset. They are unobservable until rewritten.
- Write accepted = wr_en && (!full || rd_en). On an accepted write, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accepted = rd_en && !empty. On an accepted read, data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr increments.
- Read latency is 1 cycle: data appears on the edge that accepts the read. When no read is accepted, data_out <= 0 and valid_out <= 0.
- Both pointers wrap modulo DEPTH. fill_level is tracked as an explicit counter:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- Simultaneous read and write:
  - Not empty and not full: both accepted, level unchanged.
  - Full: both accepted, level stays DEPTH, full stays 1.
  - Empty: write accepted, read rejected (no fall-through), level becomes 1, underflow set.
- Write while full without read: data dropped, pointers unchanged, overflow <= 1.
- Read while empty: ignored, underflow <= 1.
- overflow and underflow stay set until reset.
- All flags are combinational decodes of the registered fill_level, so they change on the same edge as the level.
- Read-after-write to the same slot: a word written on edge N is readable at the earliest on edge N+1.
- Reset asserted mid-transfer aborts it. No partial state survives; the first accepted write after reset lands in slot 0.

Optional Feature:
Macro FIFO_CLEAR_ON_READ_EN.
- Defined: on each accepted read, the slot mem[rd_ptr] is written to 0 in the same cycle. The write port takes priority if wr_ptr == rd_ptr on a simultaneous access while full.
- Undefined: read slots retain their old contents until overwritten. Externally visible port behaviour is identical in both cases.

Test Plan:
- Reset, then idle: empty=1, almost_empty=1, full=0, fill_level=0, data_out=0, valid_out=0, overflow=0, underflow=0.
- Write 0x001..0x008 on 8 consecutive cycles, then read 8 cycles:
  - after write 6, almost_full=1
  - after write 8, full=1
  - reads return 0x001..0x008 in order with valid_out=1, each one cycle after its rd_en
  - empty=1 at the end
- Fill to 8, then write 0x3FF with rd_en=0: overflow=1, fill_level stays 8. The subsequent 8 reads never return 0x3FF.
- Fill to 8, then wr_en=rd_en=1 with data_in 0x155: read returns the oldest word, fill_level stays 8, and 0x155 is returned eighth after the swap. Also covers pointer wrap past slot 7.
- Empty FIFO, wr_en=rd_en=1, data_in 0x0AA:
  - valid_out=0, underflow=1, fill_level=1
  - next read returns 0x0AA
- Assert reset asynchronously (between clock edges) with fill_level=5: all outputs clear immediately without a clock edge. Write 0x011 then read: returns 0x011, not stale data.

Source files
------------

// File: rtl/fifo_mem_param.sv
// -----------------------------------------------------------------------------
// fifo_mem_param
//
// Parametrised single-clock FIFO with a registered read port, fill-level
// counter, full/empty and almost-full/almost-empty flags, and sticky
// overflow/underflow indicators.
//
// Optional build macro: FIFO_CLEAR_ON_READ_EN
//   When defined, each popped slot is zeroed in the cycle it is read. A
//   write to the same slot in that cycle takes priority. Port behaviour is
//   identical with or without the macro.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   wr_en         write request
//   data_in       write data (DATA_WIDTH)
//   rd_en         read request
//   data_out      registered read data (DATA_WIDTH), 0 when nothing was popped
//   valid_out     data_out holds a word popped on the previous edge
//   full          fill_level == DEPTH
//   empty         fill_level == 0
//   almost_full   fill_level >= ALMOST_FULL_TH
//   almost_empty  fill_level <= ALMOST_EMPTY_TH
//   fill_level    words currently stored, 0..DEPTH (ADDR_WIDTH+1 bits)
//   overflow      sticky: a write was dropped because the FIFO was full
//   underflow     sticky: a read was ignored because the FIFO was empty
//
// Request semantics: wr_en and rd_en are single-cycle requests sampled on the
// rising edge. A write is accepted when not full, or when full with a read in
// the same cycle (the read frees the slot). A read is accepted when not empty;
// there is no fall-through, so a write into an empty FIFO cannot be read in
// the same cycle. Rejected requests have no effect other than setting the
// matching sticky error flag.
// -----------------------------------------------------------------------------
module fifo_mem_param #(
  parameter int DATA_WIDTH      = 10,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags are pure decodes of the registered level so they all move together.
  assign full         = (fill_level == DEPTH_LVL);
  assign empty        = (fill_level == '0);
  assign almost_full  = (fill_level >= AF_LVL);
  assign almost_empty = (fill_level <= AE_LVL);

  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_accept = wr_en && (!full || rd_en);
  assign rd_accept = rd_en && !empty;

  // Storage array: not reset, contents are unobservable until rewritten.
  always_ff @(posedge clk) begin
`ifdef FIFO_CLEAR_ON_READ_EN
    if (rd_accept) begin
      mem[rd_ptr] <= '0;
    end
`endif
    // Placed last so a same-slot write wins over the clear.
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, level, read register and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (rd_accept) begin
        rd_ptr    <= rd_ptr + 1'b1;
        data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      case ({wr_accept, rd_accept})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase

      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_mem_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_mem_param
//
// Self-checking bench for fifo_mem_param (default parameters). A queue-based
// reference model tracks stored words, expected read data and sticky flags.
// -----------------------------------------------------------------------------
module tb_fifo_mem_param;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fill_level;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  fifo_mem_param #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic void model_reset();
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endfunction

  // Reference behaviour from the FIFO rules: a read pops the oldest word if
  // any exist; a write is stored if there is room, or if a read frees room.
  function automatic void model_step(input logic w, input logic [DW-1:0] d,
                                     input logic r);
    int  lvl;
    bit  room;
    lvl  = exp_q.size();
    room = (lvl < DEPTH) || (r && lvl > 0);
    exp_dout  = '0;
    exp_valid = 1'b0;
    if (r && lvl == 0) exp_unf = 1'b1;
    if (w && !room)    exp_ovf = 1'b1;
    if (r && lvl > 0) begin
      exp_dout  = exp_q.pop_front();
      exp_valid = 1'b1;
    end
    if (w && room) exp_q.push_back(d);
  endfunction

  // ---------------------------------------------------------------- driver
  // Drives one request cycle, advances the model at the edge, returns 1ns
  // after the edge with requests dropped.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    model_step(w, d, r);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    do_reset();
    repeat (2) cycle(1'b0, '0, 1'b0);
    n_checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_flags: got e/ae/f/af=%b required 1100",
               {empty, almost_empty, full, almost_full});
    end
    n_checks++;
    if (fill_level !== '0 || data_out !== '0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got level=%0d dout=%0h valid=%b required 0/0/0",
               fill_level, data_out, valid_out);
    end
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky: got ovf=%b unf=%b required 0/0", overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (fill_level !== (AW+1)'(i) || almost_full !== (i >= AF_TH) || full !== (i == DEPTH)) begin
        n_fail++;
        $display("FAIL fill_write%0d: got level=%0d af=%b f=%b required %0d/%b/%b",
                 i, fill_level, almost_full, full, i, (i >= AF_TH), (i == DEPTH));
      end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (data_out !== DW'(i) || valid_out !== 1'b1 || data_out !== exp_dout) begin
        n_fail++;
        $display("FAIL drain_read%0d: got dout=%0h valid=%b required %0h/1",
                 i, data_out, valid_out, i);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || fill_level !== '0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got e=%b level=%0d ae=%b required 1/0/1",
               empty, fill_level, almost_empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom_range(1, 'h3FE)), 1'b0);
    cycle(1'b1, 10'h3FF, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || fill_level !== (AW+1)'(DEPTH) || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b level=%0d full=%b required 1/8/1",
               overflow, fill_level, full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (data_out !== exp_dout || valid_out !== 1'b1 || data_out === 10'h3FF) begin
        n_fail++;
        $display("FAIL overflow_read%0d: got dout=%0h valid=%b required %0h/1",
                 i, data_out, valid_out, exp_dout);
      end
    end
  endtask

  task automatic test_full_swap();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'('h040 + i), 1'b0);
    cycle(1'b1, 10'h155, 1'b1);
    n_checks++;
    if (data_out !== 10'h040 || valid_out !== 1'b1 || fill_level !== (AW+1)'(DEPTH) || full !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_full: got dout=%0h valid=%b level=%0d full=%b required 40/1/8/1",
               data_out, valid_out, fill_level, full);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (data_out !== exp_dout || valid_out !== 1'b1 ||
          (i == DEPTH && data_out !== 10'h155)) begin
        n_fail++;
        $display("FAIL swap_read%0d: got dout=%0h valid=%b required %0h/1",
                 i, data_out, valid_out, exp_dout);
      end
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    cycle(1'b1, 10'h0AA, 1'b1);
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || underflow !== 1'b1 || fill_level !== 1) begin
      n_fail++;
      $display("FAIL empty_rw: got valid=%b dout=%0h unf=%b level=%0d required 0/0/1/1",
               valid_out, data_out, underflow, fill_level);
    end
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (data_out !== 10'h0AA || valid_out !== 1'b1 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_rw_read: got dout=%0h valid=%b unf=%b required aa/1/1",
               data_out, valid_out, underflow);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'('h200 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 10'h210, 1'b0);
    cycle(1'b1, 10'h211, 1'b1);
    n_checks++;
    if (fill_level !== 5) begin
      n_fail++;
      $display("FAIL async_pre_level: got %0d required 5", fill_level);
    end
    // Mid-cycle assertion, well clear of any clock edge.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (fill_level !== '0 || empty !== 1'b1 || full !== 1'b0 || valid_out !== 1'b0 ||
        data_out !== '0 || overflow !== 1'b0 || underflow !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got level=%0d e=%b f=%b v=%b dout=%0h ovf=%b unf=%b required 0/1/0/0/0/0/0",
               fill_level, empty, full, valid_out, data_out, overflow, underflow);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 10'h011, 1'b0);
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (data_out !== 10'h011 || valid_out !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_after: got dout=%0h valid=%b empty=%b required 11/1/1",
               data_out, valid_out, empty);
    end
  endtask

  task automatic test_random();
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    int            lvl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Bias phases toward filling or draining so both boundaries are hit.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      d = DW'($urandom);
      cycle(w, d, r);
      lvl = exp_q.size();
      n_checks++;
      if (data_out !== exp_dout || valid_out !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got dout=%0h valid=%b required %0h/%b",
                 i, data_out, valid_out, exp_dout, exp_valid);
      end
      n_checks++;
      if (fill_level !== (AW+1)'(lvl) || full !== (lvl == DEPTH) || empty !== (lvl == 0) ||
          almost_full !== (lvl >= AF_TH) || almost_empty !== (lvl <= AE_TH)) begin
        n_fail++;
        $display("FAIL rand_level[%0d]: got level=%0d f=%b e=%b af=%b ae=%b required level=%0d",
                 i, fill_level, full, empty, almost_full, almost_empty, lvl);
      end
      n_checks++;
      if (overflow !== exp_ovf || underflow !== exp_unf) begin
        n_fail++;
        $display("FAIL rand_sticky[%0d]: got ovf=%b unf=%b required %b/%b",
                 i, overflow, underflow, exp_ovf, exp_unf);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_swap();
    test_empty_rw();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
